// File: rtl/teatris_unidade_controle_pkg.sv
// ============================================================================
//  teatris_pkg : shared state encodings and limits for the TEAtris control unit
//  Revision 1.0
// ============================================================================
`default_nettype none

package teatris_pkg;

   localparam logic [3:0] EST_INICIAL     = 4'h0;
   localparam logic [3:0] EST_PREPARA     = 4'h1;
   localparam logic [3:0] EST_CARREGA     = 4'h2;
   localparam logic [3:0] EST_ESPERA      = 4'h3;
   localparam logic [3:0] EST_REGISTRA    = 4'h4;
   localparam logic [3:0] EST_COMPARA     = 4'h5;
   localparam logic [3:0] EST_PROXIMA     = 4'h6;
   localparam logic [3:0] EST_PENALIDADE  = 4'h7;
   localparam logic [3:0] EST_FIM_ACERTO  = 4'hA;
   localparam logic [3:0] EST_FIM_TIMEOUT = 4'hD;
   localparam logic [3:0] EST_FIM_ERRO    = 4'hE;

   localparam int VIDAS_MAX = 7;

   typedef enum logic [3:0] {
      ST_INICIAL     = EST_INICIAL,
      ST_PREPARA     = EST_PREPARA,
      ST_CARREGA     = EST_CARREGA,
      ST_ESPERA      = EST_ESPERA,
      ST_REGISTRA    = EST_REGISTRA,
      ST_COMPARA     = EST_COMPARA,
      ST_PROXIMA     = EST_PROXIMA,
      ST_PENALIDADE  = EST_PENALIDADE,
      ST_FIM_ACERTO  = EST_FIM_ACERTO,
      ST_FIM_TIMEOUT = EST_FIM_TIMEOUT,
      ST_FIM_ERRO    = EST_FIM_ERRO
   } estado_t;

endpackage

`default_nettype wire

// File: rtl/teatris_unidade_controle_if.sv
// ============================================================================
//  teatris_unidade_controle_if : control/status bundle between FSM and datapath
//  Revision 1.0
// ============================================================================
`default_nettype none

interface teatris_unidade_controle_if;

   logic       iniciar;
   logic       tem_jogada;
   logic       jogada_ok;
   logic       fim_sequencia;
   logic       timeout;

   logic       zera_contador;
   logic       conta_contador;
   logic       enable_memoria;
   logic       registra_jogada;
   logic       compara_jogada;
   logic       timer_restart;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic [2:0] db_vidas;
   logic [3:0] db_estado;

   // master is the control unit; slave is the datapath/top-level side
   modport master (
      input  iniciar, tem_jogada, jogada_ok, fim_sequencia, timeout,
      output zera_contador, conta_contador, enable_memoria, registra_jogada,
             compara_jogada, timer_restart, pronto, acertou, errou,
             db_vidas, db_estado
   );

   modport slave (
      output iniciar, tem_jogada, jogada_ok, fim_sequencia, timeout,
      input  zera_contador, conta_contador, enable_memoria, registra_jogada,
             compara_jogada, timer_restart, pronto, acertou, errou,
             db_vidas, db_estado
   );

endinterface

`default_nettype wire

// File: rtl/teatris_unidade_controle.sv
// ============================================================================
//  teatris_unidade_controle : Moore FSM sequencing one TEAtris round, with lives
//  Revision 1.0
// ============================================================================
`default_nettype none

module teatris_unidade_controle
   import teatris_pkg::*;
#(
   parameter int VIDAS = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   teatris_unidade_controle_if.master  bus
);

   localparam logic [2:0] VIDAS_INI = 3'(VIDAS);

   if ((VIDAS < 1) || (VIDAS > VIDAS_MAX)) begin : g_vidas_invalida
      $error("VIDAS out of range 1..%0d", VIDAS_MAX);
   end

   estado_t    estado;
   estado_t    proximo;
   logic [2:0] vidas;

   logic zera_contador;
   logic conta_contador;
   logic enable_memoria;
   logic registra_jogada;
   logic compara_jogada;
   logic timer_restart;
   logic pronto;
   logic acertou;
   logic errou;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= ST_INICIAL;
         vidas  <= VIDAS_INI;
      end else begin
         estado <= proximo;
         // lives only drop on a rejected move and can never wrap below zero
         if (estado == ST_PREPARA) begin
            vidas <= VIDAS_INI;
         end else if ((estado == ST_COMPARA) && !bus.jogada_ok && (vidas != 3'd0)) begin
            vidas <= vidas - 3'd1;
         end
      end
   end

   always_comb begin
      proximo         = estado;
      zera_contador   = 1'b0;
      conta_contador  = 1'b0;
      enable_memoria  = 1'b0;
      registra_jogada = 1'b0;
      compara_jogada  = 1'b0;
      timer_restart   = 1'b0;
      pronto          = 1'b0;
      acertou         = 1'b0;
      errou           = 1'b0;

      case (estado)
         ST_INICIAL: begin
            if (bus.iniciar) proximo = ST_PREPARA;
         end
         ST_PREPARA: begin
            zera_contador = 1'b1;
            timer_restart = 1'b1;
            proximo       = ST_CARREGA;
         end
         ST_CARREGA: begin
            enable_memoria = 1'b1;
            proximo        = ST_ESPERA;
         end
         ST_ESPERA: begin
            // a move arriving together with the timeout still counts
            if (bus.tem_jogada)   proximo = ST_REGISTRA;
            else if (bus.timeout) proximo = ST_FIM_TIMEOUT;
         end
         ST_REGISTRA: begin
            registra_jogada = 1'b1;
            proximo         = ST_COMPARA;
         end
         ST_COMPARA: begin
            compara_jogada = 1'b1;
            if (bus.jogada_ok) begin
               proximo = bus.fim_sequencia ? ST_FIM_ACERTO : ST_PROXIMA;
            end else begin
               proximo = (vidas <= 3'd1) ? ST_FIM_ERRO : ST_PENALIDADE;
            end
         end
         ST_PROXIMA: begin
            conta_contador = 1'b1;
            timer_restart  = 1'b1;
            proximo        = ST_CARREGA;
         end
         ST_PENALIDADE: begin
            timer_restart = 1'b1;
            proximo       = ST_ESPERA;
         end
         ST_FIM_ACERTO: begin
            pronto  = 1'b1;
            acertou = 1'b1;
            if (bus.iniciar) proximo = ST_PREPARA;
         end
         ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
            pronto = 1'b1;
            errou  = 1'b1;
            if (bus.iniciar) proximo = ST_PREPARA;
         end
         default: begin
            proximo = ST_INICIAL;
         end
      endcase
   end

   assign bus.zera_contador   = zera_contador;
   assign bus.conta_contador  = conta_contador;
   assign bus.enable_memoria  = enable_memoria;
   assign bus.registra_jogada = registra_jogada;
   assign bus.compara_jogada  = compara_jogada;
   assign bus.timer_restart   = timer_restart;
   assign bus.pronto          = pronto;
   assign bus.acertou         = acertou;
   assign bus.errou           = errou;
   assign bus.db_vidas        = vidas;
   assign bus.db_estado       = estado;

endmodule

`default_nettype wire

// File: doc/teatris_unidade_controle.md
# teatris_unidade_controle

Control unit (Moore FSM) that sequences `teatris_fluxo_dados` through one TEAtris round: clears the piece counter, loads each pattern from memory, waits for a button move under the move timer, registers and compares it, then advances or penalises. It sits beside the datapath in the top level, driving every datapath control input and consuming its status flags. It also owns a lives counter so a wrong move costs a life instead of ending the game.

## Interface
Parameters:
- `VIDAS`, default 3: lives per game, range 1..7.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `iniciar`  in  1  start request, level, sampled in INICIAL and FIM_* states.
- `tem_jogada`  in  1  datapath: a button move is detected.
- `jogada_ok`  in  1  datapath: registered move matches memory; valid in COMPARA.
- `fim_sequencia`  in  1  datapath: counter is at the last address.
- `timeout`  in  1  datapath: move timer expired.
- `zera_contador`  out  1  datapath counter clear.
- `conta_contador`  out  1  datapath counter increment.
- `enable_memoria`  out  1  datapath memory read enable.
- `registra_jogada`  out  1  datapath move register load.
- `compara_jogada`  out  1  datapath compare strobe.
- `timer_restart`  out  1  datapath move-timer restart.
- `pronto`  out  1  round finished; held in the FIM_* states.
- `acertou`  out  1  round won; held in FIM_ACERTO.
- `errou`  out  1  round lost (lives or timeout); held in FIM_ERRO and FIM_TIMEOUT.
- `db_vidas`  out  3  remaining lives.
- `db_estado`  out  4  current state encoding.

## Operation
States and encodings:
- INICIAL (0)
- PREPARA (1)
- CARREGA (2)
- ESPERA (3)
- REGISTRA (4)
- COMPARA (5)
- PROXIMA (6)
- PENALIDADE (7)
- FIM_ACERTO (A)
- FIM_ERRO (E)
- FIM_TIMEOUT (D)

Outputs, Moore, all 0 unless listed for the state:
- PREPARA: `zera_contador`=1, `timer_restart`=1; lives loaded with `VIDAS`.
- CARREGA: `enable_memoria`=1.
- REGISTRA: `registra_jogada`=1.
- COMPARA: `compara_jogada`=1.
- PROXIMA: `conta_contador`=1, `timer_restart`=1.
- PENALIDADE: `timer_restart`=1.
- FIM_ACERTO: `pronto`=1, `acertou`=1.
- FIM_ERRO, FIM_TIMEOUT: `pronto`=1, `errou`=1.

Transitions:
- INICIAL: `iniciar` goes to PREPARA; otherwise stay.
- PREPARA always goes to CARREGA.
- CARREGA always goes to ESPERA.
- ESPERA: `tem_jogada` goes to REGISTRA; else `timeout` goes to FIM_TIMEOUT; else stay.
- REGISTRA always goes to COMPARA.
- COMPARA, when `jogada_ok`=1: go to FIM_ACERTO if `fim_sequencia`, otherwise to PROXIMA.
- COMPARA, when `jogada_ok`=0: decrement lives; go to FIM_ERRO if lives was 1, otherwise to PENALIDADE.
- PROXIMA goes to CARREGA.
- PENALIDADE goes to ESPERA. The player retries the same piece; the counter is untouched.
- FIM_*: `iniciar` goes to PREPARA, restarting a full game; otherwise hold.
- Unused encodings go to INICIAL.

Boundary rules:
- `tem_jogada` and `timeout` high together in ESPERA: the move wins and the next state is REGISTRA.
- `timeout` is ignored in every state except ESPERA.
- The lives counter never underflows. It reads 0 only in FIM_ERRO and is reloaded only in PREPARA.
- With `VIDAS`=1, the first wrong move goes straight to FIM_ERRO.
- `iniciar` held high through FIM_* restarts immediately. No edge detection is done.

## Timing
- Reset: state INICIAL, `db_estado`=0, all control and result outputs 0, `db_vidas`=`VIDAS`. Reset mid-round aborts on the next edge and overrides every transition.
- Every control strobe lasts exactly 1 cycle per state visit.
- Best-case move path, counted from the cycle `tem_jogada` is seen in ESPERA:
  - REGISTRA follows 1 cycle later.
  - COMPARA follows 2 cycles later.
  - PROXIMA follows 3 cycles later.
  - CARREGA follows 4 cycles later.
  - ESPERA follows 5 cycles later.
- `iniciar` to the first ESPERA takes 3 cycles: PREPARA, CARREGA, ESPERA.
- `jogada_ok` and `fim_sequencia` are sampled only in COMPARA. The datapath must settle them within 1 cycle of the `registra_jogada` edge.
- `db_vidas` updates on the edge leaving COMPARA.

## Structure
- Shared package `teatris_pkg` holds:
  - the state encoding constants (`EST_INICIAL` … `EST_FIM_TIMEOUT`, 4 bits);
  - `VIDAS_MAX`=7, used for the parameter range check.
- The block is a single module: state register, next-state logic, output decode and the 3-bit lives down-counter. No sub-module.
- Top level `teatris` instantiates this block and `teatris_fluxo_dados` and wires the matching names directly.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `iniciar`=0. Require `db_estado`=0, every output 0, `db_vidas`=3.
- Perfect 4-piece game: pulse `iniciar`; return `tem_jogada` 2 cycles into each ESPERA; `jogada_ok`=1; `fim_sequencia` high on the 4th compare. Require `conta_contador` to pulse 3 times, `zera_contador` once, then `pronto`=`acertou`=1 held with `db_estado`=A.
- Wrong moves: `VIDAS`=3 with `jogada_ok`=0 on every compare. Require `db_vidas` to step 3→2→1→0. Require PENALIDADE (`timer_restart` pulse, no `conta_contador`) after the 1st and 2nd errors, then FIM_ERRO, `errou`=1, `db_estado`=E.
- Timeout: in ESPERA assert `timeout` with `tem_jogada`=0. Require FIM_TIMEOUT next cycle, `db_estado`=D, `errou`=1. Then assert `timeout` and `tem_jogada` together in a fresh game: require REGISTRA.
- Restart and abort: assert `iniciar` in FIM_ACERTO and require PREPARA with `db_vidas` reloaded to 3. Assert `reset` during COMPARA and require INICIAL next cycle with no `conta_contador` pulse.
